io_uart_tx64: RTL and testbench
===============================

Name: io_uart_tx64

Overview:
- Downstream consumer of the CPU's memory-mapped output port: captures each single-cycle io_write/io_data (64-bit) strobe into a small FIFO.
- Serializes each captured word as 8 UART 8N1 byte frames on tx, byte 0 (bits [7:0]) first.
- Decouples single-cycle CPU stores from slow serial output; provides full/overflow status for debug.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit (>=2).
- FIFO_DEPTH, 4, word entries in input FIFO (power of 2, >=2).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- io_write  input  1  one-cycle strobe from CPU: push io_data
- io_data  input  64  word to transmit, sampled when io_write=1
- tx  output  1  UART serial line, idle high
- busy  output  1  1 when FIFO non-empty or serializer not IDLE
- fifo_full  output  1  FIFO holds FIFO_DEPTH words
- overflow  output  1  sticky: a write was dropped because FIFO was full
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=1 at posedge): tx=1, busy=0, fifo_full=0, overflow=0, fifo_level=0. FIFO pointers cleared, contents discarded. Serializer -> IDLE. Reset mid-frame aborts at once; tx is high from the following cycle.
- Push: io_write=1 and fifo_level<FIFO_DEPTH at the edge -> word written at tail.
- Full push: io_write=1 with FIFO full (pre-edge occupancy) -> word dropped; overflow set to 1, held until rst.
- Simultaneous push+pop: both occur; level unchanged. Push acceptance is judged on pre-edge occupancy, so a pop in the same cycle does not rescue a write to a full FIFO.
- FSM states: IDLE, START, DATA, STOP (PARITY when enabled).
  - IDLE: tx=1. If FIFO non-empty: pop head into 64-bit shift register, byte_idx=0, -> START.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA, bit_idx=0.
  - DATA: tx = current byte bit, LSB first, each held CLKS_PER_BIT cycles. After bit 7 -> STOP (or PARITY).
  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte_idx<7: byte_idx+1, shift register >>8, -> START with no idle gap. Otherwise -> IDLE.
- Latency: write sampled at edge N -> pop at edge N+1 -> tx low from edge N+1 onward.
- Frame timing: one word = 80*CLKS_PER_BIT cycles (88* with parity). Back-to-back words are separated by exactly 1 IDLE cycle (tx=1).
- Counters:
  - Bit-time counter runs 0..CLKS_PER_BIT-1 and wraps.
  - bit_idx is 3 bits; byte_idx is 3 bits, wrapping 7->0 only via IDLE.
  - FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- Status outputs:
  - fifo_full = (fifo_level==FIFO_DEPTH).
  - busy = (state!=IDLE) | (fifo_level!=0).
  - All outputs are registered or derived from registered state only; no combinational path from io_write to any output.

Optional Feature:
- Macro IO_UART_PARITY_EN.
- Defined: PARITY state inserted between DATA bit 7 and STOP. tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame = 11 bits; word = 88*CLKS_PER_BIT cycles.
- Undefined: no PARITY state; 8N1 frames, 10 bits per byte.

Test Plan:
- CLKS_PER_BIT=4, reset, single io_write with io_data=64'h0000000000000041 -> tx low 1 cycle after the sampling edge; byte 0x41 then seven 0x00 frames; busy=1 for 321 cycles, then 0; tx=1 thereafter.
- io_data=64'h0807060504030201 -> UART monitor decodes bytes 01,02,03,04,05,06,07,08 in that order, stop bits all 1, no gap between bytes.
- FIFO_DEPTH=4: 6 consecutive io_write cycles with data 1..6 -> words 1..5 accepted (word 1 popped on cycle 2), word 6 dropped. fifo_full=1 and overflow=1 after the 6th edge. Monitor receives words 1..5 only; overflow stays 1 until rst.
- Two writes back-to-back -> exactly one clk of tx=1 between last STOP of word A and START of word B; fifo_level sequence 1,1,0.
- rst asserted mid-DATA of byte 3 -> next cycle tx=1, busy=0, fifo_level=0, overflow=0. A new write after reset transmits cleanly from byte 0.
- IO_UART_PARITY_EN defined, io_data=64'h00000000000000_03 -> byte 0x03 frame has parity bit 0, byte 0x00 frames parity 0. io_data low byte 0x07 -> parity bit 1. Word duration 352 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/io_uart_tx64.sv
// Memory-mapped output port to UART bridge: buffers 64-bit CPU stores in a FIFO and sends each as 8 byte frames, LSB byte first.
// Optional even-parity bit per byte when IO_UART_PARITY_EN is defined (8E1 instead of 8N1).
module io_uart_tx64 #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          io_write,
  input  logic [63:0]                   io_data,
  output logic                          tx,
  output logic                          busy,
  output logic                          fifo_full,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

`ifdef IO_UART_PARITY_EN
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  logic [63:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_overflow;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [2:0]    r_byte_idx;
  logic [63:0]   r_shift;
  logic          r_tx;

  logic          w_push;
  logic          w_pop;
  logic          w_bit_end;
  logic [2:0]    w_next_bit;

  // Acceptance uses pre-edge occupancy, so a same-cycle pop never rescues a full-FIFO write.
  assign w_push     = io_write && (r_level != DEPTH_L);
  assign w_pop      = (r_state == S_IDLE) && (r_level != '0);
  assign w_bit_end  = (r_cnt == CNT_LAST);
  assign w_next_bit = r_bit_idx + 3'd1;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= io_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (!w_push && w_pop) begin
        r_level <= r_level - LW'(1);
      end
      if (io_write && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Serializer: r_tx is registered and updated on the same edge as each state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_tx       <= 1'b1;
    end else begin
      if (r_state == S_IDLE || w_bit_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end

      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift    <= r_mem[r_rd_ptr];
            r_byte_idx <= '0;
            r_tx       <= 1'b0;
            r_state    <= S_START;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= S_DATA;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == 3'd7) begin
`ifdef IO_UART_PARITY_EN
              r_tx    <= even_parity(r_shift[7:0]);
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_idx <= w_next_bit;
              r_tx      <= r_shift[w_next_bit];
            end
          end
        end

`ifdef IO_UART_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end
        end
`endif

        S_STOP: begin
          if (w_bit_end) begin
            if (r_byte_idx != 3'd7) begin
              r_byte_idx <= r_byte_idx + 3'd1;
              r_shift    <= r_shift >> 8;
              r_tx       <= 1'b0;
              r_state    <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx         = r_tx;
  assign busy       = (r_state != S_IDLE) || (r_level != '0);
  assign fifo_full  = (r_level == DEPTH_L);
  assign overflow   = r_overflow;
  assign fifo_level = r_level;

endmodule

// File: tb/tb_io_uart_tx64.sv
// Directed bench for io_uart_tx64: table of single-word vectors decoded by a UART monitor,
// plus hand-written overflow, back-to-back and mid-frame reset sequences.
module tb_io_uart_tx64;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef IO_UART_PARITY_EN
  localparam int FB   = 11;
  localparam int BUSY = 353;
`else
  localparam int FB   = 10;
  localparam int BUSY = 321;
`endif
  localparam int WL   = FB * 8 * CPB;
  localparam int MAXS = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_write = 1'b0;
  logic [63:0] io_data = '0;
  logic        tx;
  logic        busy;
  logic        fifo_full;
  logic        overflow;
  logic [2:0]  fifo_level;

  io_uart_tx64 #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .io_write   (io_write),
    .io_data    (io_data),
    .tx         (tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [63:0] exp_word;
    int          exp_busy;
    logic        exp_par0;
  } vec_t;

  vec_t        vt [6];
  logic [63:0] wd [8];
  logic        s_tx   [MAXS];
  logic [2:0]  s_lvl  [MAXS];
  logic        s_busy [MAXS];
  logic        s_ovf  [MAXS];
  logic        s_full [MAXS];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    io_write = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Samples every negedge; s_*[i] is the state after posedge i, and the write driven at
  // negedge i is sampled by posedge i+1.
  task automatic burst(input int nw, output int ns, output logic done);
    ns = 0;
    done = 1'b0;
    for (int i = 0; i < MAXS; i++) begin
      @(negedge clk);
      s_tx[i]   = tx;
      s_lvl[i]  = fifo_level;
      s_busy[i] = busy;
      s_ovf[i]  = overflow;
      s_full[i] = fifo_full;
      if (i < nw) begin
        io_write = 1'b1;
        io_data  = wd[i];
      end else begin
        io_write = 1'b0;
      end
      ns = i + 1;
      if (i > nw && !busy) begin
        done = 1'b1;
        break;
      end
    end
    io_write = 1'b0;
  endtask

  // UART monitor: every bit slot must be constant for CPB samples; start 0, stop 1, parity even.
  function automatic logic decode(input int base, output logic [63:0] w, output logic par0);
    logic       ok;
    logic [7:0] b;
    logic       v;
    int         p;
    ok = 1'b1;
    w = '0;
    par0 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      b = '0;
      for (int k = 0; k < FB; k++) begin
        p = base + (j * FB + k) * CPB;
        v = s_tx[p];
        for (int c = 1; c < CPB; c++) begin
          if (s_tx[p + c] !== v) ok = 1'b0;
        end
        if (k == 0) begin
          if (v !== 1'b0) ok = 1'b0;
        end else if (k <= 8) begin
          b[k - 1] = v;
        end else if (k == FB - 1) begin
          if (v !== 1'b1) ok = 1'b0;
        end else begin
          if (v !== ^b) ok = 1'b0;
          if (j == 0) par0 = v;
        end
      end
      w[j * 8 +: 8] = b;
    end
    return ok;
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    int          ns;
    int          bc;
    logic        done;
    logic        ok;
    logic        idle_ok;
    logic [63:0] w;
    logic        par0;
    wd[0] = v.data;
    burst(1, ns, done);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_lat_hi"}, s_tx[1], 1'b1);
    check({tag, "_lat_lo"}, s_tx[2], 1'b0);
    ok = decode(2, w, par0);
    check({tag, "_frame"}, ok, 1'b1);
    check({tag, "_word"}, w, v.exp_word);
`ifdef IO_UART_PARITY_EN
    check({tag, "_par0"}, par0, v.exp_par0);
`endif
    bc = 0;
    for (int i = 0; i < ns; i++) if (s_busy[i]) bc++;
    check({tag, "_busy_cyc"}, bc, v.exp_busy);
    idle_ok = 1'b1;
    for (int i = 2 + WL; i < ns; i++) if (s_tx[i] !== 1'b1) idle_ok = 1'b0;
    check({tag, "_idle_after"}, idle_ok, 1'b1);
  endtask

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int          ns;
    logic        done;
    logic        ok;
    logic        idle_ok;
    logic [63:0] w;
    logic        par0;
    int          base;
    int          lend;
    logic [2:0]  exp_lvl [7];

    vt[0] = '{64'h0000000000000041, 64'h0000000000000041, BUSY, 1'b0};
    vt[1] = '{64'h0807060504030201, 64'h0807060504030201, BUSY, 1'b1};
    vt[2] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, BUSY, 1'b0};
    vt[3] = '{64'h8000000000000001, 64'h8000000000000001, BUSY, 1'b1};
    vt[4] = '{64'h0000000000000003, 64'h0000000000000003, BUSY, 1'b0};
    vt[5] = '{64'h0000000000000007, 64'h0000000000000007, BUSY, 1'b1};
    exp_lvl = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};

    do_reset();
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_full", fifo_full, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_level", fifo_level, 3'd0);

    for (int i = 0; i < 6; i++) begin
      run_vec($sformatf("vec%0d", i), vt[i]);
    end

    // Six consecutive writes into a depth-4 FIFO: word 6 is dropped.
    for (int i = 0; i < 6; i++) wd[i] = 64'(i + 1);
    burst(6, ns, done);
    check("ovf_done", done, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      check($sformatf("ovf_level%0d", i), s_lvl[i], exp_lvl[i]);
    end
    check("ovf_full4", s_full[4], 1'b0);
    check("ovf_full6", s_full[6], 1'b1);
    check("ovf_sticky5", s_ovf[5], 1'b0);
    check("ovf_sticky6", s_ovf[6], 1'b1);
    base = 2;
    for (int k = 0; k < 5; k++) begin
      ok = decode(base, w, par0);
      check($sformatf("ovf_frame%0d", k + 1), ok, 1'b1);
      check($sformatf("ovf_word%0d", k + 1), w, 64'(k + 1));
      if (k < 4) check($sformatf("ovf_gap%0d", k + 1), s_tx[base + WL], 1'b1);
      base = base + WL + 1;
    end
    lend = 2 + 4 * (WL + 1) + WL;
    idle_ok = 1'b1;
    for (int i = lend; i < ns; i++) if (s_tx[i] !== 1'b1) idle_ok = 1'b0;
    check("ovf_no_word6", idle_ok, 1'b1);
    check("ovf_still_set", overflow, 1'b1);

    // Reset in the middle of byte 3's data bits.
    @(negedge clk);
    io_write = 1'b1;
    io_data  = 64'h1122334455667788;
    @(negedge clk);
    io_write = 1'b0;
    repeat (1 + 3 * FB * CPB + 3 * CPB) @(negedge clk);
    check("mid_busy_pre", busy, 1'b1);
    check("mid_ovf_pre", overflow, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_tx", tx, 1'b1);
    check("mid_busy", busy, 1'b0);
    check("mid_level", fifo_level, 3'd0);
    check("mid_ovf", overflow, 1'b0);
    @(negedge clk);
    check("mid_tx_hold", tx, 1'b1);
    run_vec("post_rst", vt[1]);

    // Two back-to-back writes: one idle cycle between the words.
    wd[0] = 64'hA5A5A5A5A5A5A5A5;
    wd[1] = 64'h123456789ABCDEF0;
    burst(2, ns, done);
    check("b2b_done", done, 1'b1);
    check("b2b_level1", s_lvl[1], 3'd1);
    check("b2b_level2", s_lvl[2], 3'd1);
    check("b2b_level_pre_pop", s_lvl[2 + WL], 3'd1);
    check("b2b_level_post_pop", s_lvl[3 + WL], 3'd0);
    check("b2b_gap_hi", s_tx[2 + WL], 1'b1);
    check("b2b_b_start", s_tx[3 + WL], 1'b0);
    ok = decode(2, w, par0);
    check("b2b_frameA", ok, 1'b1);
    check("b2b_wordA", w, 64'hA5A5A5A5A5A5A5A5);
    ok = decode(3 + WL, w, par0);
    check("b2b_frameB", ok, 1'b1);
    check("b2b_wordB", w, 64'h123456789ABCDEF0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
